// File: rtl/grf_write_arbiter.sv
// Single driver of the GRF write port: merges the W-stage pipe write (priority)
// with buffered long-latency results, and publishes a busy mask for hazard stalls.
module grf_write_arbiter #(
  parameter int DEPTH        = 4,
  parameter int PTR_W        = 2,
  parameter int STARVE_LIMIT = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             pipe_we,
  input  logic [4:0]       pipe_reg,
  input  logic [31:0]      pipe_data,
  input  logic [31:0]      pipe_pc,
  input  logic             async_valid,
  output logic             async_ready,
  input  logic [4:0]       async_reg,
  input  logic [31:0]      async_data,
  input  logic [31:0]      async_pc,
  output logic             writeEnable,
  output logic [4:0]       writeReg,
  output logic [31:0]      writeData,
  output logic [31:0]      PCReg,
  output logic             stall_req,
  output logic [31:0]      busy_mask,
  output logic [PTR_W:0]   pending_count
);

  localparam int SW = $clog2(STARVE_LIMIT + 1);

  logic [4:0]       entryReg  [DEPTH];
  logic [31:0]      entryData [DEPTH];
  logic [31:0]      entryPc   [DEPTH];
  logic [DEPTH-1:0] entryValid;
  logic [PTR_W-1:0] wrPtr, rdPtr;
  logic [PTR_W:0]   count;
  logic [SW-1:0]    starveCnt, starveNext;
  logic             full, empty, pipeSel, pushEn, popEn;

  assign full        = (count == (PTR_W+1)'(DEPTH));
  assign empty       = (count == '0);
  assign async_ready = reset && !full;
  assign pipeSel     = pipe_we && (pipe_reg != 5'd0);
  // Writes to r0 complete the handshake but are dropped rather than buffered.
  assign pushEn      = async_valid && async_ready && (async_reg != 5'd0);
  assign popEn       = !pipeSel && !empty;
  assign pending_count = count;

  always_comb begin
    starveNext = starveCnt;
    if (popEn || empty)
      starveNext = '0;
    else if (starveCnt != SW'(STARVE_LIMIT))
      starveNext = starveCnt + 1'b1;
  end

  always_comb begin
    busy_mask = '0;
    for (int i = 0; i < DEPTH; i++)
      if (entryValid[i])
        busy_mask[entryReg[i]] = 1'b1;
    busy_mask[0] = 1'b0;
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (!reset) begin
      wrPtr      <= '0;
      rdPtr      <= '0;
      count      <= '0;
      entryValid <= '0;
    end else begin
      if (pushEn) begin
        entryReg[wrPtr]   <= async_reg;
        entryData[wrPtr]  <= async_data;
        entryPc[wrPtr]    <= async_pc;
        entryValid[wrPtr] <= 1'b1;
        wrPtr             <= wrPtr + 1'b1;
      end
      if (popEn) begin
        entryValid[rdPtr] <= 1'b0;
        rdPtr             <= rdPtr + 1'b1;
      end
      case ({pushEn, popEn})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      starveCnt   <= '0;
      stall_req   <= 1'b0;
      writeEnable <= 1'b0;
      writeReg    <= '0;
      writeData   <= '0;
      PCReg       <= '0;
    end else begin
      starveCnt <= starveNext;
      stall_req <= (starveNext == SW'(STARVE_LIMIT));
      if (pipeSel) begin
        writeEnable <= 1'b1;
        writeReg    <= pipe_reg;
        writeData   <= pipe_data;
        PCReg       <= pipe_pc;
      end else if (popEn) begin
        writeEnable <= 1'b1;
        writeReg    <= entryReg[rdPtr];
        writeData   <= entryData[rdPtr];
        PCReg       <= entryPc[rdPtr];
      end else begin
        writeEnable <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_grf_write_arbiter.sv
// Directed bench for grf_write_arbiter: a vector table for single-edge behaviour
// plus hand-written sequences for starvation, full-FIFO and mid-run reset.
module tb_grf_write_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        pipe_we;
  logic [4:0]  pipe_reg;
  logic [31:0] pipe_data, pipe_pc;
  logic        async_valid, async_ready;
  logic [4:0]  async_reg;
  logic [31:0] async_data, async_pc;
  logic        writeEnable;
  logic [4:0]  writeReg;
  logic [31:0] writeData, PCReg;
  logic        stall_req;
  logic [31:0] busy_mask;
  logic [2:0]  pending_count;

  int checks = 0;
  int errors = 0;

  grf_write_arbiter dut (
    .clk(clk), .reset(reset),
    .pipe_we(pipe_we), .pipe_reg(pipe_reg), .pipe_data(pipe_data), .pipe_pc(pipe_pc),
    .async_valid(async_valid), .async_ready(async_ready), .async_reg(async_reg),
    .async_data(async_data), .async_pc(async_pc),
    .writeEnable(writeEnable), .writeReg(writeReg), .writeData(writeData), .PCReg(PCReg),
    .stall_req(stall_req), .busy_mask(busy_mask), .pending_count(pending_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic        pWe;
    logic [4:0]  pReg;
    logic [31:0] pData, pPc;
    logic        aValid;
    logic [4:0]  aReg;
    logic [31:0] aData, aPc;
    logic        eWe;
    logic [4:0]  eReg;
    logic [31:0] eData, ePc, eBusy;
    logic [2:0]  eCount;
    logic        eReady, eStall;
  } vec_t;

  localparam int NVEC = 21;
  vec_t vecs [NVEC];

  function automatic vec_t mkVec(logic rst, logic pWe, logic [4:0] pReg, logic [31:0] pData,
                                 logic [31:0] pPc, logic aValid, logic [4:0] aReg,
                                 logic [31:0] aData, logic [31:0] aPc, logic eWe,
                                 logic [4:0] eReg, logic [31:0] eData, logic [31:0] ePc,
                                 logic [31:0] eBusy, logic [2:0] eCount, logic eReady,
                                 logic eStall);
    vec_t v;
    v.rst = rst; v.pWe = pWe; v.pReg = pReg; v.pData = pData; v.pPc = pPc;
    v.aValid = aValid; v.aReg = aReg; v.aData = aData; v.aPc = aPc;
    v.eWe = eWe; v.eReg = eReg; v.eData = eData; v.ePc = ePc; v.eBusy = eBusy;
    v.eCount = eCount; v.eReady = eReady; v.eStall = eStall;
    return v;
  endfunction

  task automatic drive(input logic rst, input logic pWe, input logic [4:0] pReg,
                       input logic [31:0] pData, input logic [31:0] pPc, input logic aValid,
                       input logic [4:0] aReg, input logic [31:0] aData, input logic [31:0] aPc);
    reset = rst; pipe_we = pWe; pipe_reg = pReg; pipe_data = pData; pipe_pc = pPc;
    async_valid = aValid; async_reg = aReg; async_data = aData; async_pc = aPc;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkVal(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    drive(v.rst, v.pWe, v.pReg, v.pData, v.pPc, v.aValid, v.aReg, v.aData, v.aPc);
  endtask

  task automatic checkOutput(input vec_t v, input int idx);
    checkVal($sformatf("vec%0d writeEnable", idx), 32'(writeEnable), 32'(v.eWe));
    checkVal($sformatf("vec%0d writeReg", idx), 32'(writeReg), 32'(v.eReg));
    checkVal($sformatf("vec%0d writeData", idx), writeData, v.eData);
    checkVal($sformatf("vec%0d PCReg", idx), PCReg, v.ePc);
    checkVal($sformatf("vec%0d busy_mask", idx), busy_mask, v.eBusy);
    checkVal($sformatf("vec%0d pending_count", idx), 32'(pending_count), 32'(v.eCount));
    checkVal($sformatf("vec%0d async_ready", idx), 32'(async_ready), 32'(v.eReady));
    checkVal($sformatf("vec%0d stall_req", idx), 32'(stall_req), 32'(v.eStall));
  endtask

  initial begin
    //                  rst pWe pReg pData     pPc       aV aReg aData  aPc      eWe eReg eData     ePc       eBusy        cnt rdy stl
    vecs[0]  = mkVec(0, 0, 0,  0,        0,        0, 0,  0,     0,       0, 0,  0,        0,        0,           0, 0, 0);
    vecs[1]  = mkVec(0, 0, 0,  0,        0,        0, 0,  0,     0,       0, 0,  0,        0,        0,           0, 0, 0);
    vecs[2]  = mkVec(1, 0, 0,  0,        0,        0, 0,  0,     0,       0, 0,  0,        0,        0,           0, 1, 0);
    vecs[3]  = mkVec(1, 1, 5,  'h1234,   'h3000,   0, 0,  0,     0,       1, 5,  'h1234,   'h3000,   0,           0, 1, 0);
    vecs[4]  = mkVec(1, 0, 0,  0,        0,        0, 0,  0,     0,       0, 5,  'h1234,   'h3000,   0,           0, 1, 0);
    vecs[5]  = mkVec(1, 0, 0,  0,        0,        1, 8,  'hAA,  'h4000,  0, 5,  'h1234,   'h3000,   'h100,       1, 1, 0);
    vecs[6]  = mkVec(1, 0, 0,  0,        0,        0, 0,  0,     0,       1, 8,  'hAA,     'h4000,   0,           0, 1, 0);
    vecs[7]  = mkVec(1, 0, 0,  0,        0,        0, 0,  0,     0,       0, 8,  'hAA,     'h4000,   0,           0, 1, 0);
    vecs[8]  = mkVec(1, 0, 0,  0,        0,        1, 0,  'hFF,  'h5000,  0, 8,  'hAA,     'h4000,   0,           0, 1, 0);
    vecs[9]  = mkVec(1, 0, 0,  0,        0,        0, 0,  0,     0,       0, 8,  'hAA,     'h4000,   0,           0, 1, 0);
    vecs[10] = mkVec(1, 0, 0,  0,        0,        1, 7,  'h77,  'h6000,  0, 8,  'hAA,     'h4000,   'h80,        1, 1, 0);
    vecs[11] = mkVec(1, 1, 0,  'hDEAD,   'h7000,   0, 0,  0,     0,       1, 7,  'h77,     'h6000,   0,           0, 1, 0);
    vecs[12] = mkVec(1, 0, 0,  0,        0,        0, 0,  0,     0,       0, 7,  'h77,     'h6000,   0,           0, 1, 0);
    vecs[13] = mkVec(1, 0, 0,  0,        0,        1, 10, 'h10,  'h100,   0, 7,  'h77,     'h6000,   'h400,       1, 1, 0);
    vecs[14] = mkVec(1, 0, 0,  0,        0,        1, 11, 'h11,  'h104,   1, 10, 'h10,     'h100,    'h800,       1, 1, 0);
    vecs[15] = mkVec(1, 0, 0,  0,        0,        0, 0,  0,     0,       1, 11, 'h11,     'h104,    0,           0, 1, 0);
    vecs[16] = mkVec(1, 0, 0,  0,        0,        0, 0,  0,     0,       0, 11, 'h11,     'h104,    0,           0, 1, 0);
    vecs[17] = mkVec(1, 1, 3,  'h33,     'h200,    1, 12, 'h12,  'h108,   1, 3,  'h33,     'h200,    'h1000,      1, 1, 0);
    vecs[18] = mkVec(1, 1, 4,  'h44,     'h204,    0, 0,  0,     0,       1, 4,  'h44,     'h204,    'h1000,      1, 1, 0);
    vecs[19] = mkVec(1, 0, 0,  0,        0,        0, 0,  0,     0,       1, 12, 'h12,     'h108,    0,           0, 1, 0);
    vecs[20] = mkVec(1, 0, 0,  0,        0,        0, 0,  0,     0,       0, 12, 'h12,     'h108,    0,           0, 1, 0);

    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < NVEC; i++) begin
      applyStimulus(vecs[i]);
      tick();
      checkOutput(vecs[i], i);
    end

    // Fill the FIFO behind a continuous pipe stream until the head starves.
    for (int k = 1; k <= 4; k++) begin
      drive(1, 1, 9, 32'h900 + 32'(k), 32'h9000 + 32'(4 * k), 1, 5'(k), 32'h100 + 32'(k),
            32'h8000 + 32'(4 * k));
      tick();
    end
    checkVal("full writeEnable", 32'(writeEnable), 1);
    checkVal("full writeReg", 32'(writeReg), 9);
    checkVal("full async_ready", 32'(async_ready), 0);
    checkVal("full pending_count", 32'(pending_count), 4);
    checkVal("full busy_mask", busy_mask, 32'h1E);
    drive(1, 1, 9, 32'h999, 32'h9999, 0, 0, 0, 0);
    for (int k = 5; k <= 8; k++) tick();
    checkVal("starve7 stall_req", 32'(stall_req), 0);
    tick();
    checkVal("starve8 stall_req", 32'(stall_req), 1);
    tick();
    checkVal("starve sat stall_req", 32'(stall_req), 1);
    checkVal("starve sat pending", 32'(pending_count), 4);

    // Pipe drops; offer a push while still full, it must not be accepted.
    drive(1, 0, 0, 0, 0, 1, 5, 32'h55, 32'h5555);
    #1;
    checkVal("full pop async_ready", 32'(async_ready), 0);
    tick();
    checkVal("pop1 writeEnable", 32'(writeEnable), 1);
    checkVal("pop1 writeReg", 32'(writeReg), 1);
    checkVal("pop1 writeData", writeData, 32'h101);
    checkVal("pop1 PCReg", PCReg, 32'h8004);
    checkVal("pop1 stall_req", 32'(stall_req), 0);
    checkVal("pop1 pending_count", 32'(pending_count), 3);
    checkVal("pop1 busy_mask", busy_mask, 32'h1C);
    drive(1, 0, 0, 0, 0, 0, 0, 0, 0);
    for (int k = 2; k <= 4; k++) begin
      tick();
      checkVal($sformatf("pop%0d writeEnable", k), 32'(writeEnable), 1);
      checkVal($sformatf("pop%0d writeReg", k), 32'(writeReg), 32'(k));
      checkVal($sformatf("pop%0d writeData", k), writeData, 32'h100 + 32'(k));
    end
    checkVal("drained busy_mask", busy_mask, 0);
    checkVal("drained pending_count", 32'(pending_count), 0);
    tick();
    checkVal("drained writeEnable", 32'(writeEnable), 0);

    // Buffer three entries, then reset: they must vanish without committing.
    for (int k = 0; k < 3; k++) begin
      drive(1, 1, 9, 32'h909, 32'h9090, 1, 5'(20 + k), 32'h200 + 32'(k), 32'hA000);
      tick();
    end
    checkVal("prereset pending_count", 32'(pending_count), 3);
    checkVal("prereset busy_mask", busy_mask, 32'h0070_0000);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    tick();
    checkVal("reset writeEnable", 32'(writeEnable), 0);
    checkVal("reset writeReg", 32'(writeReg), 0);
    checkVal("reset pending_count", 32'(pending_count), 0);
    checkVal("reset busy_mask", busy_mask, 0);
    checkVal("reset async_ready", 32'(async_ready), 0);
    drive(1, 0, 0, 0, 0, 0, 0, 0, 0);
    for (int k = 0; k < 3; k++) begin
      tick();
      checkVal($sformatf("postreset%0d writeEnable", k), 32'(writeEnable), 0);
      checkVal($sformatf("postreset%0d pending_count", k), 32'(pending_count), 0);
    end
    checkVal("postreset async_ready", 32'(async_ready), 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
